// File: rtl/riscv_defines.sv
// Shared fetch-FSM encoding and default thread configuration for the MT prefetch buffer.
// Pure definitions: no logic, no latency, no flow control.
package riscv_defines;

  localparam int NUM_THREADS_DEF   = 4;
  localparam int THREAD_ADDR_WIDTH = $clog2(NUM_THREADS_DEF);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    WAIT_RVALID
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/riscv_mt_fetch_fifo.sv
// Single-thread word+address FIFO with flush; head visible combinationally, write lands next cycle.
// Flush beats write and pop in the same cycle; a write into a full FIFO is dropped.
module riscv_mt_fetch_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [31:0]                wr_data,
  input  logic [31:0]                wr_addr,
  input  logic                       rd_en,
  output logic                       valid,
  output logic [31:0]                rd_data,
  output logic [31:0]                rd_addr,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]      data_mem [DEPTH];
  logic [31:0]      addr_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign valid   = (count != '0);
  assign do_wr   = wr_en && !flush && (count != CNT_W'(DEPTH));
  assign do_rd   = rd_en && !flush && valid;
  assign rd_data = data_mem[rd_ptr];
  assign rd_addr = addr_mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= ptr_inc(wr_ptr);
      if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(do_wr) - CNT_W'(do_rd);
    end
  end

  // Storage is cleared on reset so the head reads as zero until first write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        addr_mem[i] <= '0;
      end
    end else if (do_wr) begin
      data_mem[wr_ptr] <= wr_data;
      addr_mem[wr_ptr] <= wr_addr;
    end
  end

endmodule

// File: rtl/riscv_mt_prefetch_buffer.sv
// Multi-threaded prefetch buffer: per-thread PC and word FIFO, one round-robin shared memory port.
// Earliest data two cycles after request; per-thread credits stop fetching when a FIFO would overfill.
module riscv_mt_prefetch_buffer
  import riscv_defines::*;
#(
  parameter int          NUM_THREADS = NUM_THREADS_DEF,
  parameter int          FIFO_DEPTH  = 2,
  parameter logic [31:0] BOOT_ADDR   = 32'h0000_0080,
  parameter int          THREAD_W    = $clog2(NUM_THREADS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_THREADS-1:0] thread_en_i,
  input  logic                   pc_set_i,
  input  logic [THREAD_W-1:0]    pc_set_thread_i,
  input  logic [31:0]            pc_set_addr_i,
  input  logic [THREAD_W-1:0]    rd_thread_i,
  input  logic                   ready_i,
  output logic [NUM_THREADS-1:0] valid_o,
  output logic [31:0]            rdata_o,
  output logic [31:0]            addr_o,
  output logic                   instr_req_o,
  input  logic                   instr_gnt_i,
  output logic [31:0]            instr_addr_o,
  input  logic [31:0]            instr_rdata_i,
  input  logic                   instr_rvalid_i,
  output logic                   busy_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_e          state_q;
  fetch_state_e          state_d;
  logic [THREAD_W-1:0]   tag_q;
  logic [THREAD_W-1:0]   rr_ptr_q;
  logic [THREAD_W-1:0]   winner;
  logic [THREAD_W-1:0]   req_thread;
  logic [31:0]           addr_q;
  logic                  stale_q;
  logic [31:0]           fetch_pc [NUM_THREADS];

  logic [NUM_THREADS-1:0] eligible;
  logic [NUM_THREADS-1:0] fifo_wr;
  logic [NUM_THREADS-1:0] fifo_rd;
  logic [NUM_THREADS-1:0] fifo_flush;
  logic [CNT_W-1:0]       fifo_cnt  [NUM_THREADS];
  logic [31:0]            fifo_data [NUM_THREADS];
  logic [31:0]            fifo_addr [NUM_THREADS];

  logic any_elig;
  logic new_req;
  logic grant;
  logic req_stale;
  logic redirect_tag;
  logic rsp_accept;

  function automatic logic [THREAD_W-1:0] rr_idx(input logic [THREAD_W-1:0] p, input int off);
    return THREAD_W'((32'(p) + 32'(off)) % NUM_THREADS);
  endfunction

  // Credit: free slots minus the one reserved by an in-flight request for the same thread.
  always_comb begin
    eligible = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      eligible[t] = thread_en_i[t]
                 && !(pc_set_i && (pc_set_thread_i == THREAD_W'(t)))
                 && ((32'(fifo_cnt[t])
                      + (((state_q != IDLE) && (tag_q == THREAD_W'(t))) ? 32'd1 : 32'd0))
                     < 32'(FIFO_DEPTH));
    end
  end

  // Scan offsets high to low so the lowest offset from the pointer wins.
  always_comb begin
    winner   = rr_ptr_q;
    any_elig = 1'b0;
    for (int i = NUM_THREADS - 1; i >= 0; i--) begin
      if (eligible[rr_idx(rr_ptr_q, i)]) begin
        winner   = rr_idx(rr_ptr_q, i);
        any_elig = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    new_req      = 1'b0;
    req_thread   = tag_q;
    req_stale    = stale_q;
    instr_req_o  = 1'b0;
    instr_addr_o = addr_q;
    grant        = 1'b0;

    case (state_q)
      IDLE:        new_req = any_elig;
      WAIT_GNT:    instr_req_o = 1'b1;
      WAIT_RVALID: new_req = instr_rvalid_i && any_elig;
      default:     new_req = 1'b0;
    endcase

    if (rst) new_req = 1'b0;

    if (new_req) begin
      instr_req_o  = 1'b1;
      req_thread   = winner;
      req_stale    = 1'b0;
      instr_addr_o = fetch_pc[winner];
    end

    grant = instr_req_o && instr_gnt_i;

    case (state_q)
      IDLE: begin
        if (new_req) state_d = instr_gnt_i ? WAIT_RVALID : WAIT_GNT;
      end
      WAIT_GNT: begin
        if (instr_gnt_i) state_d = WAIT_RVALID;
      end
      WAIT_RVALID: begin
        if (instr_rvalid_i) begin
          if (new_req) state_d = instr_gnt_i ? WAIT_RVALID : WAIT_GNT;
          else         state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign redirect_tag = pc_set_i && (pc_set_thread_i == tag_q);
  assign rsp_accept   = (state_q == WAIT_RVALID) && instr_rvalid_i && !stale_q && !redirect_tag;
  assign busy_o       = (state_q != IDLE) || instr_req_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      tag_q    <= '0;
      addr_q   <= '0;
      stale_q  <= 1'b0;
      rr_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      if (new_req) begin
        tag_q  <= winner;
        addr_q <= fetch_pc[winner];
      end
      if (new_req)                               stale_q <= 1'b0;
      else if ((state_q != IDLE) && redirect_tag) stale_q <= 1'b1;
      if (grant) rr_ptr_q <= rr_idx(req_thread, 1);
    end
  end

  // A stale request must not advance the PC: it already holds the redirect target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < NUM_THREADS; t++) fetch_pc[t] <= BOOT_ADDR;
    end else begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        if (fifo_flush[t])
          fetch_pc[t] <= word_align(pc_set_addr_i);
        else if (grant && !req_stale && (req_thread == THREAD_W'(t)))
          fetch_pc[t] <= fetch_pc[t] + 32'd4;
      end
    end
  end

  for (genvar t = 0; t < NUM_THREADS; t++) begin : g_thread
    assign fifo_wr[t]    = rsp_accept && (tag_q == THREAD_W'(t));
    assign fifo_flush[t] = pc_set_i && (pc_set_thread_i == THREAD_W'(t));
    assign fifo_rd[t]    = ready_i && (rd_thread_i == THREAD_W'(t));

    riscv_mt_fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush   (fifo_flush[t]),
      .wr_en   (fifo_wr[t]),
      .wr_data (instr_rdata_i),
      .wr_addr (addr_q),
      .rd_en   (fifo_rd[t]),
      .valid   (valid_o[t]),
      .rd_data (fifo_data[t]),
      .rd_addr (fifo_addr[t]),
      .count   (fifo_cnt[t])
    );
  end

  always_comb begin
    rdata_o = '0;
    addr_o  = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (rd_thread_i == THREAD_W'(t)) begin
        rdata_o = fifo_data[t];
        addr_o  = fifo_addr[t];
      end
    end
  end

endmodule

// File: tb/tb_riscv_mt_prefetch_buffer.sv
// Directed bench for the MT prefetch buffer: a memory responder logs handshakes,
// expected request addresses and popped words are queued and compared as the DUT produces them.
module tb_riscv_mt_prefetch_buffer;

  localparam int NT = 4;

  logic          clk;
  logic          rst;
  logic [NT-1:0] thread_en_i;
  logic          pc_set_i;
  logic [1:0]    pc_set_thread_i;
  logic [31:0]   pc_set_addr_i;
  logic [1:0]    rd_thread_i;
  logic          ready_i;
  logic [NT-1:0] valid_o;
  logic [31:0]   rdata_o;
  logic [31:0]   addr_o;
  logic          instr_req_o;
  logic          instr_gnt_i;
  logic [31:0]   instr_addr_o;
  logic [31:0]   instr_rdata_i;
  logic          instr_rvalid_i;
  logic          busy_o;

  int checks = 0;
  int errors = 0;

  int          rv_delay = 0;
  logic        mem_busy = 1'b0;
  int          mem_wait = 0;
  logic [31:0] mem_addr = '0;

  typedef struct packed {
    logic [1:0]  thread;
    logic [31:0] addr;
  } pop_t;

  logic [31:0] req_log [$];
  logic [31:0] exp_req [$];
  pop_t        exp_pop [$];

  riscv_mt_prefetch_buffer #(
    .NUM_THREADS (NT),
    .FIFO_DEPTH  (2),
    .BOOT_ADDR   (32'h0000_0080)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .thread_en_i     (thread_en_i),
    .pc_set_i        (pc_set_i),
    .pc_set_thread_i (pc_set_thread_i),
    .pc_set_addr_i   (pc_set_addr_i),
    .rd_thread_i     (rd_thread_i),
    .ready_i         (ready_i),
    .valid_o         (valid_o),
    .rdata_o         (rdata_o),
    .addr_o          (addr_o),
    .instr_req_o     (instr_req_o),
    .instr_gnt_i     (instr_gnt_i),
    .instr_addr_o    (instr_addr_o),
    .instr_rdata_i   (instr_rdata_i),
    .instr_rvalid_i  (instr_rvalid_i),
    .busy_o          (busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Memory responder: answers rv_delay cycles after the grant cycle, logs every handshake.
  initial begin
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = '0;
    forever begin
      @(negedge clk);
      instr_rvalid_i = 1'b0;
      if (mem_busy) begin
        if (mem_wait == 0) begin
          instr_rvalid_i = 1'b1;
          instr_rdata_i  = mem_data(mem_addr);
          mem_busy       = 1'b0;
        end else begin
          mem_wait = mem_wait - 1;
        end
      end
      #4;
      if (instr_req_o && instr_gnt_i && !rst) begin
        mem_busy = 1'b1;
        mem_wait = rv_delay;
        mem_addr = instr_addr_o;
        req_log.push_back(instr_addr_o);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reqs(input string tag);
    check({tag, "_count"}, 32'(req_log.size()), 32'(exp_req.size()));
    while (exp_req.size() > 0 && req_log.size() > 0)
      check(tag, req_log.pop_front(), exp_req.pop_front());
    req_log.delete();
    exp_req.delete();
  endtask

  task automatic drain();
    pop_t e;
    while (exp_pop.size() > 0) begin
      e = exp_pop.pop_front();
      @(negedge clk);
      rd_thread_i = e.thread;
      ready_i     = 1'b0;
      #2;
      check("pop_valid", 32'(valid_o[e.thread]), 32'd1);
      check("pop_rdata", rdata_o, mem_data(e.addr));
      check("pop_addr",  addr_o, e.addr);
      ready_i = 1'b1;
      @(negedge clk);
      ready_i = 1'b0;
    end
  endtask

  task automatic push_pop(input logic [1:0] t, input logic [31:0] a);
    pop_t e;
    e.thread = t;
    e.addr   = a;
    exp_pop.push_back(e);
  endtask

  initial begin
    rst             = 1'b1;
    thread_en_i     = 4'b1111;
    pc_set_i        = 1'b0;
    pc_set_thread_i = '0;
    pc_set_addr_i   = '0;
    rd_thread_i     = '0;
    ready_i         = 1'b0;
    instr_gnt_i     = 1'b1;

    // Reset values
    cycles(2);
    #2;
    check("rst_req",   32'(instr_req_o), 32'd0);
    check("rst_iaddr", instr_addr_o, 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_addr",  addr_o, 32'd0);
    check("rst_busy",  32'(busy_o), 32'd0);

    // Round-robin boot fetch, then first-data latency
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) exp_req.push_back(32'h80);
    for (int i = 0; i < 4; i++) exp_req.push_back(32'h84);
    #2;
    check("s1_req_n",   32'(instr_req_o), 32'd1);
    check("s1_addr_n",  instr_addr_o, 32'h80);
    check("s1_busy_n",  32'(busy_o), 32'd1);
    @(negedge clk);
    #2;
    check("s1_valid_n1", 32'(valid_o), 32'd0);
    check("s1_b2b_req",  32'(instr_req_o), 32'd1);
    @(negedge clk);
    #2;
    check("s1_valid_n2", 32'(valid_o), 32'b0001);
    cycles(20);
    #2;
    check("s1_valid_all", 32'(valid_o), 32'b1111);
    check("s1_idle_req",  32'(instr_req_o), 32'd0);
    check("s1_idle_busy", 32'(busy_o), 32'd0);
    check_reqs("s1_req");

    // Thread 1 stays full: only threads 0, 2, 3 refill
    push_pop(2'd0, 32'h80); push_pop(2'd0, 32'h84);
    push_pop(2'd2, 32'h80); push_pop(2'd2, 32'h84);
    push_pop(2'd3, 32'h80); push_pop(2'd3, 32'h84);
    drain();
    cycles(15);
    #2;
    check("s2_req_count", 32'(req_log.size()), 32'd6);
    check("s2_valid", 32'(valid_o), 32'b1111);
    req_log.delete();
    thread_en_i = 4'b0000;
    push_pop(2'd0, 32'h88); push_pop(2'd0, 32'h8C);
    push_pop(2'd1, 32'h80); push_pop(2'd1, 32'h84);
    push_pop(2'd2, 32'h88); push_pop(2'd2, 32'h8C);
    push_pop(2'd3, 32'h88); push_pop(2'd3, 32'h8C);
    drain();
    #2;
    check("s2_empty", 32'(valid_o), 32'd0);

    // Redirect thread 2 while its request waits for rvalid
    rv_delay = 2;
    @(negedge clk);
    thread_en_i = 4'b0100;
    exp_req.push_back(32'h90);
    exp_req.push_back(32'h1000);
    exp_req.push_back(32'h1004);
    #2;
    check("s3_req_addr", instr_addr_o, 32'h90);
    @(negedge clk);
    pc_set_i = 1'b1; pc_set_thread_i = 2'd2; pc_set_addr_i = 32'h1002;
    @(negedge clk);
    pc_set_i = 1'b0;
    cycles(15);
    thread_en_i = 4'b0000;
    #2;
    check("s3_valid", 32'(valid_o), 32'b0100);
    check_reqs("s3_req");
    push_pop(2'd2, 32'h1000); push_pop(2'd2, 32'h1004);
    drain();

    // Grant withheld for 5 cycles while the tag thread is redirected and halted
    rv_delay = 0;
    @(negedge clk);
    thread_en_i = 4'b1000;
    instr_gnt_i = 1'b0;
    exp_req.push_back(32'h90);
    exp_req.push_back(32'h2000);
    exp_req.push_back(32'h2004);
    #2;
    check("s4_req_addr", instr_addr_o, 32'h90);
    @(negedge clk);
    thread_en_i = 4'b0000;
    pc_set_i = 1'b1; pc_set_thread_i = 2'd3; pc_set_addr_i = 32'h2000;
    #2;
    check("s4_hold_req",  32'(instr_req_o), 32'd1);
    check("s4_hold_addr", instr_addr_o, 32'h90);
    @(negedge clk);
    pc_set_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      check("s4_hold_req",  32'(instr_req_o), 32'd1);
      check("s4_hold_addr", instr_addr_o, 32'h90);
      @(negedge clk);
    end
    instr_gnt_i = 1'b1;
    thread_en_i = 4'b1000;
    cycles(8);
    thread_en_i = 4'b0000;
    #2;
    check("s4_valid", 32'(valid_o), 32'b1000);
    check_reqs("s4_req");
    push_pop(2'd3, 32'h2000); push_pop(2'd3, 32'h2004);
    drain();

    // Pop and redirect of the same thread in one cycle
    @(negedge clk);
    thread_en_i = 4'b0011;
    cycles(12);
    thread_en_i = 4'b0000;
    #2;
    check("s5_full", 32'(valid_o), 32'b0011);
    @(negedge clk);
    rd_thread_i = 2'd0; ready_i = 1'b1;
    pc_set_i = 1'b1; pc_set_thread_i = 2'd0; pc_set_addr_i = 32'h3000;
    @(negedge clk);
    ready_i = 1'b0; pc_set_i = 1'b0;
    #2;
    check("s5_flushed", 32'(valid_o), 32'b0010);
    req_log.delete();
    push_pop(2'd1, 32'h88);
    drain();

    // Reset while a response is outstanding; the late rvalid must be ignored
    rv_delay = 3;
    @(negedge clk);
    rd_thread_i = 2'd1;
    thread_en_i = 4'b0001;
    #2;
    check("s6_req_addr", instr_addr_o, 32'h3000);
    @(negedge clk);
    rst = 1'b1;
    thread_en_i = 4'b0000;
    #2;
    check("s6_rst_req",   32'(instr_req_o), 32'd0);
    check("s6_rst_busy",  32'(busy_o), 32'd0);
    check("s6_rst_valid", 32'(valid_o), 32'd0);
    check("s6_rst_rdata", rdata_o, 32'd0);
    check("s6_rst_addr",  addr_o, 32'd0);
    check("s6_rst_iaddr", instr_addr_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cycles(5);
    #2;
    check("s6_late_valid", 32'(valid_o), 32'd0);
    check("s6_late_busy",  32'(busy_o), 32'd0);
    @(negedge clk);
    thread_en_i = 4'b0001;
    #2;
    check("s6_boot_req",  32'(instr_req_o), 32'd1);
    check("s6_boot_addr", instr_addr_o, 32'h80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
